// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART frame receiver.
package uart_frame_pkg;

  // Frame-level parser states.
  typedef enum logic [1:0] {
    StHunt,
    StGetLen,
    StPayload,
    StCsum
  } frame_state_e;

  // Byte-level receiver states.
  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  localparam logic [7:0] DefaultHeader = 8'hA5;

  // Inter-byte timeout in clock cycles.
  function automatic int unsigned calc_timeout(input int unsigned freq,
                                               input int unsigned baud,
                                               input int unsigned bits);
    return (freq / baud) * bits;
  endfunction

  // Clock cycles per 1/16 bit time; never below one cycle.
  function automatic int unsigned calc_os_div(input int unsigned freq,
                                              input int unsigned baud);
    int unsigned cpb;
    cpb = freq / baud;
    return (cpb >= 16) ? (cpb / 16) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 16x oversampled 8N1 byte receiver. Bytes with a bad stop bit are dropped silently.
module uart_rx_byte
  import uart_frame_pkg::*;
#(
  parameter int unsigned FREQUENCY_IN = 100_000_000,
  parameter int unsigned BAUD_RATE    = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] byte_data,
  output logic       byte_valid
);

  localparam int unsigned OsDiv = calc_os_div(FREQUENCY_IN, BAUD_RATE);
  localparam int unsigned DivW  = (OsDiv > 1) ? $clog2(OsDiv) : 1;

  rx_state_e       state_q, state_d;
  logic [1:0]      sync_q;
  logic [DivW-1:0] div_q, div_d;
  logic [3:0]      os_q, os_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            rx_s;
  logic            tick;

  assign rx_s = sync_q[1];
  assign tick = (div_q == DivW'(OsDiv - 1));

  // Two-flop synchroniser for the asynchronous pin, idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_in};
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RxIdle;
      div_q   <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end

  // Start detect, mid-bit sampling of data (LSB first) and stop bit check.
  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DivW'(1);
    os_d    = os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    unique case (state_q)
      RxIdle: begin
        div_d = '0;
        os_d  = '0;
        if (!rx_s) state_d = RxStart;
      end
      RxStart: begin
        if (tick) begin
          if (os_q == 4'd7) begin
            // Half a bit in: confirm the start bit, else treat it as a glitch.
            os_d  = '0;
            bit_d = '0;
            state_d = rx_s ? RxIdle : RxData;
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      RxData: begin
        if (tick) begin
          if (os_q == 4'd15) begin
            os_d    = '0;
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = RxStop;
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      RxStop: begin
        if (tick) begin
          if (os_q == 4'd15) begin
            valid_d = rx_s;
            state_d = RxIdle;
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign byte_data  = shift_q;
  assign byte_valid = valid_q;

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver: HEADER, LEN, payload, optional checksum, presented on a valid/ready bus.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned FREQUENCY_IN = 100_000_000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  HEADER       = DefaultHeader,
  parameter int unsigned TIMEOUT_BITS = 15,
  parameter bit          CHECKSUM_EN  = 1'b1,
  parameter bit          MSB_FIRST    = 1'b0,
  localparam int unsigned LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [8*MAX_LEN-1:0] frame_data,
  output logic [LEN_W-1:0]     frame_len,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic                 err_timeout,
  output logic                 err_len,
  output logic                 err_csum,
  output logic                 err_overrun
);

  localparam int unsigned DataW      = 8 * MAX_LEN;
  localparam int unsigned SelW       = $clog2(DataW);
  localparam int unsigned TimeOutNum = calc_timeout(FREQUENCY_IN, BAUD_RATE, TIMEOUT_BITS);
  localparam int unsigned TW         = $clog2(TimeOutNum + 1);

  logic [7:0] byte_data;
  logic       byte_valid;

  uart_rx_byte #(
    .FREQUENCY_IN(FREQUENCY_IN),
    .BAUD_RATE   (BAUD_RATE)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .byte_data (byte_data),
    .byte_valid(byte_valid)
  );

  frame_state_e     state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [DataW-1:0] buf_q, buf_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [DataW-1:0] frame_data_q, frame_data_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             frame_valid_q, frame_valid_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_len_q, err_len_d;
  logic             err_csum_q, err_csum_d;
  logic             err_overrun_q, err_overrun_d;
  logic             commit;
  logic             expire;
  logic [SelW-1:0]  slot_base;

  // Bit offset of the payload slot for the current byte index.
  always_comb begin
    if (MSB_FIRST) begin
      slot_base = SelW'(8 * (MAX_LEN - 1 - 32'(idx_q)));
    end else begin
      slot_base = SelW'(8 * 32'(idx_q));
    end
  end

  // Timeout fires when the count of cycles since the last byte would reach TimeOutNum;
  // a byte arriving in that cycle takes priority.
  assign expire = (state_q != StHunt) && !byte_valid && (tcnt_q == TW'(TimeOutNum - 1));

  // Parser state, assembly buffer, checksum and timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StHunt;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      buf_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      buf_q   <= buf_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Frame parser next state; raises commit when a complete, valid frame has been assembled.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    sum_d         = sum_q;
    buf_d         = buf_q;
    commit        = 1'b0;
    err_len_d     = 1'b0;
    err_csum_d    = 1'b0;
    err_timeout_d = 1'b0;

    if (byte_valid) begin
      tcnt_d = TW'(1);
    end else if (state_q == StHunt) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end

    unique case (state_q)
      StHunt: begin
        if (byte_valid && (byte_data == HEADER)) begin
          buf_d   = '0;
          sum_d   = '0;
          state_d = StGetLen;
        end
      end
      StGetLen: begin
        if (byte_valid) begin
          if ((byte_data != 8'd0) && (32'(byte_data) <= MAX_LEN)) begin
            len_d   = byte_data[LEN_W-1:0];
            idx_d   = '0;
            sum_d   = byte_data;
            state_d = StPayload;
          end else begin
            err_len_d = 1'b1;
            state_d   = StHunt;
          end
        end else if (expire) begin
          err_timeout_d = 1'b1;
          state_d       = StHunt;
        end
      end
      StPayload: begin
        if (byte_valid) begin
          buf_d[slot_base +: 8] = byte_data;
          sum_d = sum_q + byte_data;
          idx_d = idx_q + LEN_W'(1);
          if (idx_q == len_q - LEN_W'(1)) begin
            if (CHECKSUM_EN) begin
              state_d = StCsum;
            end else begin
              commit  = 1'b1;
              state_d = StHunt;
            end
          end
        end else if (expire) begin
          err_timeout_d = 1'b1;
          state_d       = StHunt;
        end
      end
      StCsum: begin
        if (byte_valid) begin
          if (byte_data == sum_q) begin
            commit = 1'b1;
          end else begin
            err_csum_d = 1'b1;
          end
          state_d = StHunt;
        end else if (expire) begin
          err_timeout_d = 1'b1;
          state_d       = StHunt;
        end
      end
      default: state_d = StHunt;
    endcase

    if (expire) tcnt_d = '0;
  end

  // Output holding register and error pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_data_q  <= '0;
      frame_len_q   <= '0;
      frame_valid_q <= 1'b0;
      err_timeout_q <= 1'b0;
      err_len_q     <= 1'b0;
      err_csum_q    <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      frame_data_q  <= frame_data_d;
      frame_len_q   <= frame_len_d;
      frame_valid_q <= frame_valid_d;
      err_timeout_q <= err_timeout_d;
      err_len_q     <= err_len_d;
      err_csum_q    <= err_csum_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  // Load a committed frame if the slot is free or being drained this cycle, else drop it.
  always_comb begin
    frame_data_d  = frame_data_q;
    frame_len_d   = frame_len_q;
    frame_valid_d = frame_valid_q;
    err_overrun_d = 1'b0;
    if (commit) begin
      if (!frame_valid_q || frame_ready) begin
        frame_data_d  = buf_d;
        frame_len_d   = len_q;
        frame_valid_d = 1'b1;
      end else begin
        err_overrun_d = 1'b1;
      end
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_len   = frame_len_q;
  assign frame_valid = frame_valid_q;
  assign err_timeout = err_timeout_q;
  assign err_len     = err_len_q;
  assign err_csum    = err_csum_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: two instances (LSB-first and MSB-first packing) on one line.
module tb_uart_frame_rx;

  localparam int unsigned Freq       = 3200;
  localparam int unsigned Baud       = 100;
  localparam int unsigned BitClks    = 32;   // Freq / Baud
  localparam int unsigned TimeOutNum = 480;  // 32 * 15

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        ready_a;
  logic        ready_b;
  logic [31:0] data_a, data_b;
  logic [2:0]  len_a, len_b;
  logic        fv_a, fv_b;
  logic        eto_a, elen_a, ecs_a, eov_a;
  logic        eto_b, elen_b, ecs_b, eov_b;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .FREQUENCY_IN(Freq), .BAUD_RATE(Baud), .MAX_LEN(4), .HEADER(8'hA5),
    .TIMEOUT_BITS(15), .CHECKSUM_EN(1'b1), .MSB_FIRST(1'b0)
  ) u_dut_a (
    .clk(clk), .rst(rst), .rx_in(rx), .frame_data(data_a), .frame_len(len_a),
    .frame_valid(fv_a), .frame_ready(ready_a), .err_timeout(eto_a), .err_len(elen_a),
    .err_csum(ecs_a), .err_overrun(eov_a)
  );

  uart_frame_rx #(
    .FREQUENCY_IN(Freq), .BAUD_RATE(Baud), .MAX_LEN(4), .HEADER(8'hA5),
    .TIMEOUT_BITS(15), .CHECKSUM_EN(1'b1), .MSB_FIRST(1'b1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .rx_in(rx), .frame_data(data_b), .frame_len(len_b),
    .frame_valid(fv_b), .frame_ready(ready_b), .err_timeout(eto_b), .err_len(elen_b),
    .err_csum(ecs_b), .err_overrun(eov_b)
  );

  // Byte strobe of instance A, used only as the timing reference for latency checks.
  wire bv_a = u_dut_a.u_rx.byte_valid;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_bv = -10;
  int fv_cnt = 0, fv_cyc = 0;
  int csum_cnt = 0, csum_cyc = 0;
  int len_cnt = 0, len_cyc = 0;
  int to_cnt = 0, to_cyc = 0;
  int ov_cnt = 0, ov_cyc = 0;
  int b_cnt = 0, b_err_cnt = 0;
  logic [31:0] cap_data = '0, b_data = '0, post_data = '0;
  logic [2:0]  cap_len = '0, b_len = '0, post_len = '0;
  logic        post_valid = 1'b0;
  logic        fv_prev = 1'b0, fvb_prev = 1'b0;
  bit          raised;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled mid-cycle.
  always @(negedge clk) begin
    fv_prev  <= fv_a;
    fvb_prev <= fv_b;
    if (bv_a) last_bv <= cyc;
    if (cyc == last_bv + 1) begin
      post_valid <= fv_a;
      post_data  <= data_a;
      post_len   <= len_a;
    end
    if (fv_a === 1'b1 && fv_prev === 1'b0) begin
      fv_cnt   <= fv_cnt + 1;
      fv_cyc   <= cyc;
      cap_data <= data_a;
      cap_len  <= len_a;
    end
    if (fv_b === 1'b1 && fvb_prev === 1'b0) begin
      b_cnt  <= b_cnt + 1;
      b_data <= data_b;
      b_len  <= len_b;
    end
    if (ecs_a === 1'b1) begin csum_cnt <= csum_cnt + 1; csum_cyc <= cyc; end
    if (elen_a === 1'b1) begin len_cnt <= len_cnt + 1; len_cyc <= cyc; end
    if (eto_a === 1'b1) begin to_cnt <= to_cnt + 1; to_cyc <= cyc; end
    if (eov_a === 1'b1) begin ov_cnt <= ov_cnt + 1; ov_cyc <= cyc; end
    if ((eto_b | elen_b | ecs_b | eov_b) === 1'b1) b_err_cnt <= b_err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 8N1, LSB first; optionally raise ready_a in the cycle this byte's strobe appears.
  task automatic send_byte(input logic [7:0] b, input bit raise);
    rx = 1'b0;
    repeat (BitClks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BitClks) @(negedge clk);
    end
    rx = 1'b1;
    for (int k = 0; k < int'(BitClks); k++) begin
      @(negedge clk);
      if (raise && !raised && bv_a) begin
        ready_a = 1'b1;
        raised  = 1'b1;
      end
    end
  endtask

  // Bytes packed first-byte-most-significant in the low n bytes of v.
  task automatic send_frame(input logic [63:0] v, input int n, input bit raise_last);
    for (int k = 0; k < n; k++) begin
      send_byte(v[8*(n-1-k) +: 8], raise_last && (k == n - 1));
    end
    repeat (40) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    rx      = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    raised  = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_valid", 32'(fv_a), 32'd0);
    check("reset_data", data_a, 32'h0);
    check("reset_len", 32'(len_a), 32'd0);
    check("reset_errs", 32'({eto_a, elen_a, ecs_a, eov_a}), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Good frame, both packing orders.
    send_frame(64'hA5_03_11_22_33_69, 6, 1'b0);
    check("good_count", fv_cnt, 1);
    check("good_latency", 32'(fv_cyc - last_bv), 32'd1);
    check("good_len", 32'(cap_len), 32'd3);
    check("good_data_lsb", cap_data, 32'h0033_2211);
    check("good_data_msb", b_data, 32'h1122_3300);
    check("good_len_msb", 32'(b_len), 32'd3);
    check("good_drained", 32'(fv_a), 32'd0);

    // Line noise before the header.
    send_frame(64'h00_FF_A5_01_7E_7F, 6, 1'b0);
    check("noise_count", fv_cnt, 2);
    check("noise_len", 32'(cap_len), 32'd1);
    check("noise_data", cap_data, 32'h0000_007E);

    // Bad checksum, then recovery.
    send_frame(64'hA5_03_11_22_33_68, 6, 1'b0);
    check("csum_pulses", csum_cnt, 1);
    check("csum_latency", 32'(csum_cyc - last_bv), 32'd1);
    check("csum_no_frame", fv_cnt, 2);
    send_frame(64'hA5_02_10_20_32, 5, 1'b0);
    check("csum_recover_count", fv_cnt, 3);
    check("csum_recover_data", cap_data, 32'h0000_2010);
    check("csum_recover_len", 32'(cap_len), 32'd2);

    // Bad lengths (too long, zero), then recovery.
    send_frame(64'hA5_05, 2, 1'b0);
    check("len_big_pulse", len_cnt, 1);
    check("len_big_latency", 32'(len_cyc - last_bv), 32'd1);
    send_frame(64'hA5_00, 2, 1'b0);
    check("len_zero_pulse", len_cnt, 2);
    send_frame(64'hA5_01_44_45, 4, 1'b0);
    check("len_recover_count", fv_cnt, 4);
    check("len_recover_data", cap_data, 32'h0000_0044);

    // Inter-byte timeout.
    check("no_early_timeout", to_cnt, 0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    repeat (600) @(negedge clk);
    check("timeout_pulse", to_cnt, 1);
    check("timeout_latency", 32'(to_cyc - last_bv), 32'(TimeOutNum));
    check("timeout_no_frame", fv_cnt, 4);
    send_frame(64'hA5_03_01_02_03_09, 6, 1'b0);
    check("timeout_recover_count", fv_cnt, 5);
    check("timeout_recover_data", cap_data, 32'h0003_0201);

    // Overrun: first frame held, second dropped.
    ready_a = 1'b0;
    send_frame(64'hA5_01_55_56, 4, 1'b0);
    check("hold_count", fv_cnt, 6);
    check("hold_data", cap_data, 32'h0000_0055);
    send_frame(64'hA5_02_AA_BB_67, 5, 1'b0);
    check("overrun_pulse", ov_cnt, 1);
    check("overrun_latency", 32'(ov_cyc - last_bv), 32'd1);
    check("overrun_valid", 32'(fv_a), 32'd1);
    check("overrun_data", data_a, 32'h0000_0055);
    check("overrun_len", 32'(len_a), 32'd1);

    // Replace: ready rises in the commit cycle of the next frame.
    send_frame(64'hA5_01_33_34, 4, 1'b1);
    check("replace_ready_seen", 32'(raised), 32'd1);
    check("replace_valid", 32'(post_valid), 32'd1);
    check("replace_data", post_data, 32'h0000_0033);
    check("replace_len", 32'(post_len), 32'd1);
    check("replace_no_overrun", ov_cnt, 1);
    check("replace_drained", 32'(fv_a), 32'd0);

    // Reset mid-frame with a frame held.
    ready_a = 1'b0;
    send_frame(64'hA5_01_66_67, 4, 1'b0);
    check("held_before_reset", 32'(fv_a), 32'd1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(fv_a), 32'd0);
    check("rst_data", data_a, 32'h0);
    check("rst_len", 32'(len_a), 32'd0);
    repeat (600) @(negedge clk);
    check("rst_no_errors", 32'(csum_cnt + len_cnt + to_cnt + ov_cnt), 32'd5);
    ready_a = 1'b1;
    send_frame(64'hA5_02_77_88_01, 5, 1'b0);
    check("rst_recover_count", fv_cnt, 8);
    check("rst_recover_data", cap_data, 32'h0000_8877);
    check("msb_inst_errors", b_err_cnt, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
